step_dir_rx: RTL

//  Step/direction receiver: the input-side counterpart of the axis pulse/dir generator.
//  It samples an external STEP/DIR pair (from a driver loop-back or an upstream controller),

---
 rtl/step_dir_rx.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/step_dir_rx.sv
// step_dir_rx: step/direction receiver with glitch filters, signed position count,
// MCU snapshot, reference-switch homing capture and sticky error flags.
//
//   state | meaning
//   IDLE  | homing capture disarmed
//   ARMED | next filtered Ref falling edge captures and zeroes the position
//   DONE  | capture taken, RefDone high until RefClr
module step_dir_rx #(
   parameter int CNT_W     = 16,
   parameter int FILT_LEN  = 4,
   parameter int DIR_SETUP = 2
) (
   input  logic             Clk,
   input  logic             gRst,
   input  logic             StepIn,
   input  logic             DirIn,
   input  logic             Ref,
   input  logic             PosLock,
   input  logic             DirRev,
   input  logic             CntEn,
   input  logic             CntClr,
   input  logic             RefEn,
   input  logic             RefClr,
   input  logic             ErrClr,
   output logic [CNT_W-1:0] PosCnt,
   output logic [CNT_W-1:0] PosLatch,
   output logic [CNT_W-1:0] RefPos,
   output logic             RefDone,
   output logic             StepStb,
   output logic             SetupErr,
   output logic             OvfErr
);
   localparam int FCNT_W = $clog2(FILT_LEN + 1);
   localparam int AGE_W  = (DIR_SETUP < 1) ? 1 : $clog2(DIR_SETUP + 1);
   localparam int BLANK  = FILT_LEN + 2;
   localparam int BLK_W  = $clog2(BLANK + 1);
   localparam logic [CNT_W-1:0] POS_MAX = {1'b0, {(CNT_W-1){1'b1}}};
   localparam logic [CNT_W-1:0] POS_MIN = {1'b1, {(CNT_W-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, ARMED, DONE} home_t;
   home_t state, state_nxt;

   // bit order in the line vectors: 0 step, 1 dir, 2 ref, 3 lock (lock is unfiltered)
   logic [3:0]        sync1, sync2;
   logic [2:0]        filt, filt_nxt, filt_prev;
   logic [FCNT_W-1:0] fcnt     [3];
   logic [FCNT_W-1:0] fcnt_nxt [3];
   logic              lock_prev;
   logic [BLK_W-1:0]  blank_cnt;
   logic [AGE_W-1:0]  dir_age;
   logic live, step_rise, ref_fall, lock_rise, capture;
   logic dropped, step_ok, step_up, step_cnt, setup_hit, ovf_hit;

   always_comb begin
      for (int i = 0; i < 3; i++) begin
         filt_nxt[i] = filt[i];
         fcnt_nxt[i] = '0;
         if (sync2[i] != filt[i]) begin
            if (fcnt[i] == FCNT_W'(FILT_LEN - 1))
               filt_nxt[i] = sync2[i];
            else
               fcnt_nxt[i] = fcnt[i] + FCNT_W'(1);
         end
      end
   end

   assign live      = (blank_cnt == '0);
   assign step_rise = live & filt[0] & ~filt_prev[0];
   assign ref_fall  = live & ~filt[2] & filt_prev[2];
   assign lock_rise = live & sync2[3] & ~lock_prev;

   always_comb begin
      state_nxt = state;
      capture   = 1'b0;
      case (state)
         IDLE:    if (RefEn) state_nxt = ARMED;
         ARMED: begin
            if (ref_fall) begin
               capture   = 1'b1;
               state_nxt = DONE;
            end else if (!RefEn) begin
               state_nxt = IDLE;
            end
         end
         DONE:    if (RefClr) state_nxt = RefEn ? ARMED : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign dropped   = CntClr | capture;
   assign step_ok   = step_rise & ~dropped;
   assign step_up   = filt[1] ^ DirRev;
   assign step_cnt  = step_ok & CntEn;
   assign setup_hit = step_ok & (dir_age < AGE_W'(DIR_SETUP));
   assign ovf_hit   = step_cnt & (step_up ? (PosCnt == POS_MAX) : (PosCnt == POS_MIN));
   assign RefDone   = (state == DONE);

   always_ff @(posedge Clk) begin
      if (gRst) begin
         sync1     <= '0;
         sync2     <= '0;
         filt      <= '0;
         filt_prev <= '0;
         for (int i = 0; i < 3; i++) fcnt[i] <= '0;
         lock_prev <= 1'b0;
         blank_cnt <= BLK_W'(BLANK);
         dir_age   <= '0;
         state     <= IDLE;
         StepStb   <= 1'b0;
         PosCnt    <= '0;
         PosLatch  <= '0;
         RefPos    <= '0;
         SetupErr  <= 1'b0;
         OvfErr    <= 1'b0;
      end else begin
         sync1 <= {PosLock, Ref, DirIn, StepIn};
         sync2 <= sync1;
         filt  <= filt_nxt;
         for (int i = 0; i < 3; i++) fcnt[i] <= fcnt_nxt[i];
         // while blanked, history follows the new value so start-up transitions never look like edges
         filt_prev <= live ? filt : filt_nxt;
         lock_prev <= live ? sync2[3] : sync1[3];
         if (!live) blank_cnt <= blank_cnt - BLK_W'(1);
         if (filt_nxt[1] != filt[1])
            dir_age <= '0;
         else if (dir_age < AGE_W'(DIR_SETUP))
            dir_age <= dir_age + AGE_W'(1);
         state   <= state_nxt;
         StepStb <= step_rise;
         if (dropped)
            PosCnt <= '0;
         else if (step_cnt)
            PosCnt <= step_up ? PosCnt + CNT_W'(1) : PosCnt - CNT_W'(1);
         if (capture)   RefPos   <= PosCnt;
         if (lock_rise) PosLatch <= PosCnt;
         SetupErr <= (SetupErr & ~ErrClr) | setup_hit;
         OvfErr   <= (OvfErr & ~ErrClr) | ovf_hit;
      end
   end
endmodule
